// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package data_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE,
    CLEAR
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Index width of the storage array; at least one bit even for a single word.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, registered read, storage never reset.
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 256,
  localparam int IW = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts a read/write request, waits WAIT_STATES cycles,
// accesses the array and pulses ack. Optional power-up clear via `define MEM_CLEAR_EN.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          err,
  output logic          busy
);

  localparam int IW = idx_width(DEPTH);
`ifdef MEM_CLEAR_EN
  // Reset parks the FSM in CLEAR so the sweep starts on the first edge after release.
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic          cap_cmd;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          in_range;
  logic          mem_we;
  logic [IW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;
`ifdef MEM_CLEAR_EN
  logic [IW-1:0] clr_cnt;
`endif

  assign in_range = ({1'b0, cap_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (WAIT_STATES == 0) ? ACCESS : WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
`ifdef MEM_CLEAR_EN
      CLEAR:   if (clr_cnt == IW'(DEPTH - 1)) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // In IDLE the array is addressed straight from the port so a read issued with
  // WAIT_STATES = 0 has its data registered by the time ACCESS closes.
  always_comb begin
    busy      = (state != IDLE);
    mem_we    = 1'b0;
    mem_addr  = (state == IDLE) ? addr[IW-1:0] : cap_addr[IW-1:0];
    mem_wdata = cap_wdata;
    if (state == ACCESS) mem_we = (cap_cmd == CMD_WRITE) && in_range && !rst;
`ifdef MEM_CLEAR_EN
    if (state == CLEAR) begin
      mem_we    = !rst;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      cap_cmd   <= cmd;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req && WAIT_STATES != 0) cnt <= 4'(WAIT_STATES - 1);
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        ACCESS: begin
          ack <= 1'b1;
          err <= !in_range;
          if (cap_cmd == CMD_READ) rdata <= in_range ? mem_q : '0;
        end
        DONE: begin
          ack <= 1'b0;
          err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + IW'(1);
  end
`endif

  mem_array #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .q    (mem_q)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_STATES=0/DEPTH=256 and
// WAIT_STATES=3/DEPTH=200) checked against an array model of the memory.
module tb_data_mem_responder;

  localparam int WS0 = 0, DEPTH0 = 256;
  localparam int WS1 = 3, DEPTH1 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], req[2], cmd[2];
  logic [7:0] addr[2], wdata[2], rdata[2];
  logic       ack[2], err[2], busy[2];

  data_mem_responder #(.AW(8), .DW(8), .DEPTH(DEPTH0), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .cmd(cmd[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );

  data_mem_responder #(.AW(8), .DW(8), .DEPTH(DEPTH1), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .cmd(cmd[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  int tests = 0;
  int fails = 0;

  // Reference model: word contents and the last value rdata should show.
  logic [7:0] mem_m[2][256];
  logic [7:0] rdata_m[2];

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; DUT must be idle on entry and is idle on exit.
  task automatic txn(input int d, input logic c, input logic [7:0] a, input logic [7:0] w,
                     input bit garble);
    int  k;
    bit  exp_err;
    exp_err = (int'(a) >= depth_of(d));
    if (c == 1'b1) begin
      if (!exp_err) mem_m[d][a] = w;
    end else begin
      rdata_m[d] = exp_err ? 8'h00 : mem_m[d][a];
    end
    req[d] = 1'b1; cmd[d] = c; addr[d] = a; wdata[d] = w;
    step();
    check("busy_after_accept", d, busy[d], 1);
    k = 0;
    while (ack[d] !== 1'b1 && k < ws_of(d) + 4) begin
      if (garble) begin
        req[d]   = 1'($urandom_range(0, 1));
        cmd[d]   = 1'($urandom_range(0, 1));
        addr[d]  = 8'($urandom_range(0, 255));
        wdata[d] = 8'($urandom_range(0, 255));
      end
      step();
      k++;
    end
    req[d] = 1'b0;
    check("ack_latency", d, k, ws_of(d) + 1);
    check("err_with_ack", d, err[d], exp_err);
    check("rdata_with_ack", d, rdata[d], rdata_m[d]);
    step();
    check("ack_one_cycle", d, ack[d], 0);
    check("err_cleared", d, err[d], 0);
    check("busy_back_idle", d, busy[d], 0);
    check("rdata_held", d, rdata[d], rdata_m[d]);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_ack", d, ack[d], 0);
    check("rst_err", d, err[d], 0);
    check("rst_rdata", d, rdata[d], 0);
`ifndef MEM_CLEAR_EN
    check("rst_busy", d, busy[d], 0);
`endif
  endtask

  // Called with rst high, just after an edge.
  task automatic release_reset(input int d);
    int k;
    int n_ack;
    rst[d] = 1'b0;
    rdata_m[d] = 8'h00;
`ifdef MEM_CLEAR_EN
    req[d] = 1'b1; cmd[d] = 1'b1; addr[d] = 8'h01; wdata[d] = 8'hEE;
    k = 0;
    n_ack = 0;
    do begin
      step();
      k++;
      if (ack[d] === 1'b1) n_ack++;
    end while (busy[d] === 1'b1 && k < depth_of(d) + 4);
    req[d] = 1'b0;
    check("clear_busy_cycles", d, k, depth_of(d));
    check("clear_no_ack", d, n_ack, 0);
    for (int i = 0; i < depth_of(d); i++) mem_m[d][i] = 8'h00;
`else
    k = 0;
    n_ack = 0;
    check("busy_after_release", d, busy[d], 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; cmd[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      rdata_m[d] = 8'h00;
    end
    repeat (3) step();
    check_reset_outputs(0);
    check_reset_outputs(1);
    release_reset(0);
    release_reset(1);

`ifdef MEM_CLEAR_EN
    for (int i = 0; i < 16; i++) txn(1, 1'b0, 8'(i), 8'h00, 1'b0);
`endif

    // Write then read with no wait states; rdata untouched by the write.
    txn(0, 1'b1, 8'h12, 8'hA5, 1'b0);
    txn(0, 1'b0, 8'h12, 8'h00, 1'b0);

    // Three wait states.
    txn(1, 1'b1, 8'h12, 8'h5C, 1'b0);
    txn(1, 1'b0, 8'h12, 8'h00, 1'b0);

    // Out of range on the 200-word instance.
    txn(1, 1'b1, 8'h00, 8'h3C, 1'b0);
    txn(1, 1'b1, 8'hC8, 8'hFF, 1'b0);
    txn(1, 1'b0, 8'hC8, 8'h00, 1'b0);
    txn(1, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(1, 1'b0, 8'hFF, 8'h00, 1'b0);

    // Inputs wiggled while busy: only the captured write may land.
    txn(1, 1'b1, 8'h40, 8'h5A, 1'b1);
    txn(1, 1'b0, 8'h40, 8'h00, 1'b0);

    // Fill every implemented word so later reads have known contents.
    for (int i = 0; i < DEPTH0; i++) txn(0, 1'b1, 8'(i), 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < DEPTH1; i++) txn(1, 1'b1, 8'(i), 8'($urandom_range(0, 255)), 1'b0);

    // Randomized mix, including garbled inputs during waits.
    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 2; d++) begin
        txn(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), (d == 1) && ($urandom_range(0, 3) == 0));
      end
    end

    // Reset during WAIT of a write: write never performed, no ack.
    txn(1, 1'b1, 8'h05, 8'h11, 1'b0);
    txn(1, 1'b0, 8'h05, 8'h00, 1'b0);
    req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 8'h05; wdata[1] = 8'h77;
    step();
    step();
    rst[1] = 1'b1;
    req[1] = 1'b0;
    step();
    check_reset_outputs(1);
    release_reset(1);
    txn(1, 1'b0, 8'h05, 8'h00, 1'b0);

    // Reset on the ACCESS edge of a write: reset wins.
    txn(0, 1'b1, 8'h33, 8'h22, 1'b0);
    req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 8'h33; wdata[0] = 8'h99;
    step();
    rst[0] = 1'b1;
    req[0] = 1'b0;
    step();
    check_reset_outputs(0);
    release_reset(0);
    txn(0, 1'b0, 8'h33, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
